seq_detect_param: RTL and testbench
===================================

# seq_detect_param

Runtime-configurable serial bit-pattern detector, the parametrised successor to the team's fixed 3-bit Mealy/Moore detectors. Pattern, pattern length (1..MAX_LEN), overlap/non-overlap mode and Mealy/Moore output mode are all selectable at run time. It adds input qualification and a saturating match counter. It sits on a serial bit stream behind a valid strobe and drives a single-cycle match pulse to downstream control logic.

## Interface

- MAX_LEN, 8, maximum pattern length in bits (2..16)
- LEN_W, 5, width of cfg_len; must hold MAX_LEN
- CNT_W, 8, width of match_cnt
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- in_valid  input  1  qualifies `in`; a bit is consumed only when high
- in  input  1  serial data bit
- cfg_load  input  1  one-cycle strobe; captures all cfg_* inputs
- cfg_pattern  input  MAX_LEN  pattern bits; cfg_pattern[len-1] is the first bit received, cfg_pattern[0] the last
- cfg_len  input  LEN_W  pattern length
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
- cfg_moore  input  1  1 = Moore (registered) output, 0 = Mealy (combinational) output
- clr_cnt  input  1  synchronous clear of match_cnt
- out  output  1  match pulse
- match_cnt  output  CNT_W  number of matches, saturating

## Operation

- Config registers: pat, len, ovl, moore. Reset values: pat = 101 in the low bits (upper bits 0), len = 3, ovl = 1, moore = 0. The default equals the 101 Mealy overlap detector.
- Length clamp on cfg_load: cfg_len = 0 loads 1; cfg_len > MAX_LEN loads MAX_LEN.
- History: hist (MAX_LEN-1 bits) shifts in `in` on each consumed bit, newest at bit 0. hcnt counts valid history bits and saturates at MAX_LEN-1.
- Match condition (combinational), all of the following:
  - in_valid = 1
  - cfg_load = 0
  - hcnt >= len-1
  - the low `len` bits of {hist, in} equal pat[len-1:0]
- On match:
  - ovl = 1: history keeps shifting normally, so suffix reuse is allowed.
  - ovl = 0: hcnt clears to 0 and the next match needs len fresh bits.
- Output:
  - Mealy (moore = 0): out = match, in the same cycle.
  - Moore (moore = 1): out = registered match, asserted exactly one cycle after the completing bit and held for one cycle only.
- Mode switch: out_r is always updated from match. `out` muxes between the two sources according to moore.
- match_cnt increments by 1 on each match cycle and saturates at 2^CNT_W-1.
  - clr_cnt forces it to 0 and has priority over an increment in the same cycle.
- cfg_load:
  - Captures the config registers and clears hcnt and out_r.
  - The `in` bit in that cycle is discarded.
  - match_cnt is unaffected.
- in_valid = 0: hist, hcnt and match_cnt hold. Mealy out = 0. out_r captures 0, so a Moore pulse still ends after one cycle.

## Timing

- Reset (asynchronous assert, synchronous release): hist = 0, hcnt = 0, out_r = 0, match_cnt = 0, config registers at the defaults above. out = 0 during reset.
- Mealy latency: 0 cycles from the completing bit's clock cycle.
- Moore latency: 1 cycle.
- Configuration takes effect for bits consumed from the cycle after cfg_load.
- Throughput: one bit per cycle. Back-to-back matches are possible, e.g. len = 1 or overlap on 11…1.
- Reset mid-pattern discards partial history. A pending Moore pulse is dropped.
- Simultaneous cfg_load and match-candidate bit: the bit is discarded and no match occurs.

## Test plan

- Default config after reset, Mealy overlap: stream 1,0,1,0,1 (valid every cycle) → out high on bits 3 and 5, match_cnt = 2.
- cfg_load pattern 101, len 3, ovl = 0, moore = 1; stream 1,0,1,0,1,1,0,1 → out high one cycle after bits 3 and 8 only, match_cnt = 2.
- len = 8, pattern 0xA5, overlap Mealy; stream 1010_0101_1010_0101 → matches on bits 8 and 16; gaps in in_valid inserted mid-pattern must not change the result.
- cfg_len = 0 → behaves as len 1 with pat[0] = 1: every valid 1 gives out = 1. cfg_len = 20 → clamps to MAX_LEN.
- CNT_W = 3, 9 matches → match_cnt saturates at 7. clr_cnt asserted in a match cycle → match_cnt = 0.
- Assert rst asynchronously after 1,0 of 101, then send 1 → no match. A Moore pulse pending at reset never appears.

Source files
------------

// File: rtl/seq_detect_param.sv
// ---------------------------------------------------------------------------
// seq_detect_param
//
// Runtime-configurable serial bit-pattern detector. It watches a serial bit
// stream qualified by in_valid and pulses `out` whenever the most recent
// `len` consumed bits equal the configured pattern. Detection may be
// overlapping or non-overlapping, and the pulse may be Mealy (same cycle as
// the completing bit) or Moore (one cycle later). A saturating counter
// tallies matches.
//
// Parameters
//   MAX_LEN  maximum pattern length in bits (2..16)
//   LEN_W    width of cfg_len, must be able to hold MAX_LEN
//   CNT_W    width of match_cnt
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   in_valid     qualifies `in`; a bit is consumed only when high
//   in           serial data bit
//   cfg_load     one-cycle strobe capturing all cfg_* inputs
//   cfg_pattern  pattern; cfg_pattern[len-1] is the first bit received
//   cfg_len      pattern length (0 loads 1, values above MAX_LEN load MAX_LEN)
//   cfg_overlap  1 = overlapping detection, 0 = non-overlapping
//   cfg_moore    1 = registered (Moore) output, 0 = combinational (Mealy)
//   clr_cnt      synchronous clear of match_cnt, wins over an increment
//   out          match pulse
//   match_cnt    saturating number of matches
// ---------------------------------------------------------------------------
module seq_detect_param #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 5,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cfg_moore,
  input  logic               clr_cnt,
  output logic               out,
  output logic [CNT_W-1:0]   match_cnt
);

  // History holds one bit fewer than the longest pattern; the live `in` bit
  // supplies the final position of the comparison window.
  localparam int HIST_W = MAX_LEN - 1;

  // Power-up configuration is the classic 101 overlapping Mealy detector.
  // The length is limited to MAX_LEN so tiny instances stay self-consistent.
  localparam int                 DEF_LEN_I = (MAX_LEN < 3) ? MAX_LEN : 3;
  localparam logic [MAX_LEN-1:0] DEF_PAT   = MAX_LEN'(32'd5);
  localparam logic [LEN_W-1:0]   DEF_LEN   = LEN_W'(DEF_LEN_I);
  localparam logic [LEN_W-1:0]   LEN_MAX_V = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   HCNT_MAX  = LEN_W'(MAX_LEN - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

  // Configuration registers
  logic [MAX_LEN-1:0] pat_q,  pat_d;
  logic [LEN_W-1:0]   len_q,  len_d;
  logic               ovl_q,  ovl_d;
  logic               moore_q, moore_d;

  // Detection state
  logic [HIST_W-1:0]  hist_q, hist_d;
  logic [LEN_W-1:0]   hcnt_q, hcnt_d;
  logic               out_r_q, out_r_d;
  logic [CNT_W-1:0]   cnt_q,  cnt_d;

  // Combinational helpers
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   len_load;
  logic               consume;
  logic               history_ok;
  logic               pattern_eq;
  logic               match;

  // A configuration strobe steals the cycle: the data bit that arrives with
  // it is thrown away so the new settings apply to a clean stream.
  assign consume = in_valid & ~cfg_load;

  // Comparison window, newest bit at position 0, so pattern bit 0 lines up
  // with the bit arriving now.
  assign window = {hist_q, in};

  // Only the low `len` bits of the window take part in the compare.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
  end

  // len_q is never zero, so len_q-1 cannot wrap.
  assign history_ok = (hcnt_q >= (len_q - LEN_W'(1)));
  assign pattern_eq = (((window ^ pat_q) & len_mask) == '0);
  assign match      = consume & history_ok & pattern_eq;

  // Out-of-range lengths are folded into 1..MAX_LEN at load time so the
  // rest of the datapath never sees an illegal length.
  always_comb begin
    if (cfg_len == '0) begin
      len_load = LEN_W'(1);
    end else if (cfg_len > LEN_MAX_V) begin
      len_load = LEN_MAX_V;
    end else begin
      len_load = cfg_len;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    moore_d = moore_q;
    hist_d  = hist_q;
    hcnt_d  = hcnt_q;

    if (cfg_load) begin
      pat_d   = cfg_pattern;
      len_d   = len_load;
      ovl_d   = cfg_overlap;
      moore_d = cfg_moore;
      hcnt_d  = '0;
    end else if (in_valid) begin
      hist_d = window[HIST_W-1:0];
      // In non-overlapping mode a match consumes its bits, so the next
      // match must be built entirely from fresh input.
      if (match && !ovl_q) begin
        hcnt_d = '0;
      end else if (hcnt_q < HCNT_MAX) begin
        hcnt_d = hcnt_q + LEN_W'(1);
      end
    end
  end

  // The registered copy of match is always tracked, regardless of mode, so
  // flipping between Mealy and Moore never leaves a stale pulse behind.
  // match is already low during cfg_load, which clears the pending pulse.
  assign out_r_d = match;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (match && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q   <= DEF_PAT;
      len_q   <= DEF_LEN;
      ovl_q   <= 1'b1;
      moore_q <= 1'b0;
      hist_q  <= '0;
      hcnt_q  <= '0;
      out_r_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      moore_q <= moore_d;
      hist_q  <= hist_d;
      hcnt_q  <= hcnt_d;
      out_r_q <= out_r_d;
      cnt_q   <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    out       = moore_q ? out_r_q : match;
    match_cnt = cnt_q;
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_param
//
// Scoreboard bench for seq_detect_param. The stimulus process drives one
// cycle at a time and pushes the hand-computed out/match_cnt expected for
// that cycle; a separate monitor pops an entry at every falling edge and
// compares. A second instance with CNT_W = 3 sees identical stimulus and is
// used to observe counter saturation.
// ---------------------------------------------------------------------------
module tb_seq_detect_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 5;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cfg_moore;
  logic               clr_cnt;
  logic               out;
  logic [7:0]         match_cnt;
  logic               out_sat;
  logic [2:0]         match_cnt_sat;

  typedef struct {
    logic  exp_out;
    int    exp_cnt;
    string name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  seq_detect_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_moore(cfg_moore), .clr_cnt(clr_cnt),
    .out(out), .match_cnt(match_cnt)
  );

  seq_detect_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_moore(cfg_moore), .clr_cnt(clr_cnt),
    .out(out_sat), .match_cnt(match_cnt_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one scoreboard entry against both instances.
  task automatic checkOutput(input exp_t e);
    int exp_sat;
    exp_sat = (e.exp_cnt > 7) ? 7 : e.exp_cnt;
    checks++;
    if (out !== e.exp_out) begin
      errors++;
      $display("[TB] FAIL %s out: got %0b expected %0b", e.name, out, e.exp_out);
    end
    checks++;
    if (int'(match_cnt) != e.exp_cnt) begin
      errors++;
      $display("[TB] FAIL %s match_cnt: got %0d expected %0d", e.name, match_cnt, e.exp_cnt);
    end
    checks++;
    if (out_sat !== e.exp_out) begin
      errors++;
      $display("[TB] FAIL %s out(cnt3): got %0b expected %0b", e.name, out_sat, e.exp_out);
    end
    checks++;
    if (int'(match_cnt_sat) != exp_sat) begin
      errors++;
      $display("[TB] FAIL %s match_cnt(cnt3): got %0d expected %0d", e.name, match_cnt_sat, exp_sat);
    end
  endtask

  // Monitor: inputs settle shortly after each rising edge, so the falling
  // edge is a safe point to look at the outputs for that cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      checkOutput(sb_q.pop_front());
    end
  end

  // Drive one data cycle and record what the DUT should show in it.
  task automatic applyStimulus(input logic v, input logic b, input logic clr,
                               input logic eo, input int ec, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    in_valid = v;
    in       = b;
    clr_cnt  = clr;
    e.exp_out = eo;
    e.exp_cnt = ec;
    e.name    = name;
    sb_q.push_back(e);
  endtask

  // Drive a configuration strobe; a valid 1 rides along to show it is ignored.
  task automatic cfgLoad(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                         input logic ovl, input logic moore,
                         input logic eo, input int ec, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    cfg_load    = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = ovl;
    cfg_moore   = moore;
    in_valid    = 1'b1;
    in          = 1'b1;
    clr_cnt     = 1'b0;
    e.exp_out = eo;
    e.exp_cnt = ec;
    e.name    = name;
    sb_q.push_back(e);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in          = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    cfg_moore   = 1'b0;
    clr_cnt     = 1'b0;

    // Reset state
    applyStimulus(0, 0, 0, 0, 0, "reset0");
    applyStimulus(0, 0, 0, 0, 0, "reset1");
    rst = 1'b0;

    // Default 101, Mealy, overlapping
    applyStimulus(1, 1, 0, 0, 0, "def_b1");
    applyStimulus(1, 0, 0, 0, 0, "def_b2");
    applyStimulus(1, 1, 0, 1, 0, "def_b3");
    applyStimulus(1, 0, 0, 0, 1, "def_b4");
    applyStimulus(1, 1, 0, 1, 1, "def_b5");
    applyStimulus(0, 0, 0, 0, 2, "def_idle");

    // 101, Moore, non-overlapping
    applyStimulus(0, 0, 1, 0, 2, "clr1");
    cfgLoad(8'h05, 5'd3, 1'b0, 1'b1, 0, 0, "cfg_moore");
    applyStimulus(1, 1, 0, 0, 0, "moo_b1");
    applyStimulus(1, 0, 0, 0, 0, "moo_b2");
    applyStimulus(1, 1, 0, 0, 0, "moo_b3");
    applyStimulus(1, 0, 0, 1, 1, "moo_b4");
    applyStimulus(1, 1, 0, 0, 1, "moo_b5");
    applyStimulus(1, 1, 0, 0, 1, "moo_b6");
    applyStimulus(1, 0, 0, 0, 1, "moo_b7");
    applyStimulus(1, 1, 0, 0, 1, "moo_b8");
    applyStimulus(0, 0, 0, 1, 2, "moo_pulse");
    applyStimulus(0, 0, 0, 0, 2, "moo_end");

    // 0xA5, len 8, Mealy overlap, with in_valid gaps carrying junk ones
    applyStimulus(0, 0, 1, 0, 2, "clr2");
    cfgLoad(8'hA5, 5'd8, 1'b1, 1'b0, 0, 0, "cfg_a5");
    applyStimulus(1, 1, 0, 0, 0, "a5_b1");
    applyStimulus(1, 0, 0, 0, 0, "a5_b2");
    applyStimulus(1, 1, 0, 0, 0, "a5_b3");
    applyStimulus(0, 1, 0, 0, 0, "a5_gap1");
    applyStimulus(0, 1, 0, 0, 0, "a5_gap2");
    applyStimulus(1, 0, 0, 0, 0, "a5_b4");
    applyStimulus(1, 0, 0, 0, 0, "a5_b5");
    applyStimulus(1, 1, 0, 0, 0, "a5_b6");
    applyStimulus(1, 0, 0, 0, 0, "a5_b7");
    applyStimulus(1, 1, 0, 1, 0, "a5_b8");
    applyStimulus(1, 1, 0, 0, 1, "a5_b9");
    applyStimulus(1, 0, 0, 0, 1, "a5_b10");
    applyStimulus(1, 1, 0, 0, 1, "a5_b11");
    applyStimulus(0, 1, 0, 0, 1, "a5_gap3");
    applyStimulus(0, 1, 0, 0, 1, "a5_gap4");
    applyStimulus(1, 0, 0, 0, 1, "a5_b12");
    applyStimulus(1, 0, 0, 0, 1, "a5_b13");
    applyStimulus(1, 1, 0, 0, 1, "a5_b14");
    applyStimulus(1, 0, 0, 0, 1, "a5_b15");
    applyStimulus(1, 1, 0, 1, 1, "a5_b16");
    applyStimulus(0, 0, 0, 0, 2, "a5_idle");

    // cfg_len = 0 behaves as length 1
    cfgLoad(8'h01, 5'd0, 1'b1, 1'b0, 0, 2, "cfg_len0");
    applyStimulus(1, 1, 0, 1, 2, "l0_b1");
    applyStimulus(1, 0, 0, 0, 3, "l0_b2");
    applyStimulus(1, 1, 0, 1, 3, "l0_b3");
    applyStimulus(1, 1, 0, 1, 4, "l0_b4");
    applyStimulus(0, 0, 0, 0, 5, "l0_idle");

    // cfg_len = 20 clamps to 8: eight ones are needed before the first match
    cfgLoad(8'hFF, 5'd20, 1'b1, 1'b0, 0, 5, "cfg_len20");
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(1, 1, 0, 0, 5, $sformatf("l20_b%0d", i));
    end
    applyStimulus(1, 1, 0, 1, 5, "l20_b8");
    applyStimulus(1, 1, 0, 1, 6, "l20_b9");
    applyStimulus(0, 0, 0, 0, 7, "l20_idle");

    // Saturation of the 3-bit counter, then clr_cnt beating a match
    applyStimulus(0, 0, 1, 0, 7, "clr3");
    cfgLoad(8'h01, 5'd1, 1'b1, 1'b0, 0, 0, "cfg_sat");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1, 1, 0, 1, i, $sformatf("sat_b%0d", i + 1));
    end
    applyStimulus(1, 1, 1, 1, 9, "sat_clr_match");
    applyStimulus(0, 0, 0, 0, 0, "sat_after_clr");

    // Asynchronous reset mid-pattern with a Moore pulse pending
    cfgLoad(8'h05, 5'd3, 1'b1, 1'b1, 0, 0, "cfg_rst");
    applyStimulus(1, 1, 0, 0, 0, "rst_b1");
    applyStimulus(1, 0, 0, 0, 0, "rst_b2");
    applyStimulus(1, 1, 0, 0, 0, "rst_b3");
    #2;
    rst = 1'b1;
    applyStimulus(1, 1, 0, 0, 0, "rst_hold");
    applyStimulus(0, 0, 0, 0, 0, "rst_release");
    rst = 1'b0;
    applyStimulus(1, 1, 0, 0, 0, "post_b1");
    applyStimulus(1, 0, 0, 0, 0, "post_b2");
    applyStimulus(1, 1, 0, 1, 0, "post_b3");
    applyStimulus(0, 0, 0, 0, 1, "post_idle");

    // Let the monitor drain the scoreboard, bounded
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
